// File: rtl/intr_gen_n.sv
// intr_gen_n: pseudo-random interrupt generator with NCH independent channels.
// Each channel waits a random multiple of MINWAIT cycles, then raises its
// request either as a held level (released by acknowledge) or a 1-cycle pulse.
module intr_gen_n #(
    parameter int unsigned    NCH        = 3,
    parameter int unsigned    MINWAIT    = 10,
    parameter logic [31:0]    SEED       = 32'hACE1_2468,
    parameter logic [NCH-1:0] PULSE_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        intr_intvl,
    input  logic              intr_en,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH-1:0]    intr_ack,
    output logic [NCH-1:0]    irq_o,
    output logic [NCH*16-1:0] irq_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ASSERT
    } chanState_t;

    // An all-zero seed would lock the LFSR, so it is swapped for 1.
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    logic [31:0]    lfsr_q;
    logic [31:0]    lfsr_d;
    chanState_t     state_q   [NCH];
    logic [24:0]    waitCnt_q [NCH];
    logic [24:0]    waitLoad_d[NCH];
    logic [15:0]    irqCnt_q  [NCH];
    logic [NCH-1:0] irq_q;

    // Per-channel constant that decorrelates the channels' random words.
    function automatic logic [15:0] chanSalt(input int i);
        logic [31:0] prod;
        prod = i * 32'h0000_9E37;
        return prod[15:0];
    endfunction

    // Wait length: (masked random + 1) quanta; the largest case fits 25 bits.
    function automatic logic [24:0] calcWait(input logic [15:0] r, input logic [3:0] intvl);
        logic [15:0] mask;
        logic [31:0] prod;
        mask = (16'h1 << intvl) - 16'h1;
        prod = (32'(r & mask) + 32'h1) * MINWAIT;
        return prod[24:0];
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Galois LFSR next state, shifting right with the feedback taps applied.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    end

    // Wait-counter load value each channel would take on leaving IDLE now.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            waitLoad_d[i] = calcWait(lfsr_q[15:0] ^ chanSalt(i), intr_intvl);
        end
    end

    // LFSR plus all channel FSMs; reset overrides every other transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
            irq_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i]   <= ST_IDLE;
                waitCnt_q[i] <= '0;
                irqCnt_q[i]  <= '0;
            end
        end else begin
            lfsr_q <= lfsr_d;
            for (int i = 0; i < NCH; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (intr_en && ch_en[i] && (intr_intvl != 4'd0)) begin
                            state_q[i]   <= ST_WAIT;
                            waitCnt_q[i] <= waitLoad_d[i];
                        end
                    end
                    ST_WAIT: begin
                        if (!(intr_en && ch_en[i])) begin
                            state_q[i]   <= ST_IDLE;
                            waitCnt_q[i] <= '0;
                        end else if (waitCnt_q[i] <= 25'd1) begin
                            state_q[i]   <= ST_ASSERT;
                            waitCnt_q[i] <= '0;
                            irq_q[i]     <= 1'b1;
                            irqCnt_q[i]  <= satInc(irqCnt_q[i]);
                        end else begin
                            waitCnt_q[i] <= waitCnt_q[i] - 25'd1;
                        end
                    end
                    ST_ASSERT: begin
                        if (PULSE_MASK[i]) begin
                            state_q[i] <= ST_IDLE;
                            irq_q[i]   <= 1'b0;
                        end else if (intr_ack[i]) begin
                            if (lfsr_q[31 - (i % 32)] || !intr_en || !ch_en[i]) begin
                                state_q[i] <= ST_IDLE;
                                irq_q[i]   <= 1'b0;
                            end else begin
                                irqCnt_q[i] <= satInc(irqCnt_q[i]);
                            end
                        end
                    end
                    default: begin
                        state_q[i]   <= ST_IDLE;
                        waitCnt_q[i] <= '0;
                        irq_q[i]     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Enables gate the request combinationally so disabling drops it at once.
    always_comb begin
        irq_o = irq_q & ch_en & {NCH{intr_en}};
    end

    // Pack the per-channel assertion counters onto the flat output bus.
    always_comb begin
        irq_cnt_o = '0;
        for (int i = 0; i < NCH; i++) begin
            irq_cnt_o[16*i +: 16] = irqCnt_q[i];
        end
    end

endmodule

// File: tb/tb_intr_gen_n.sv
// tb_intr_gen_n: directed self-checking bench for intr_gen_n.
// A slow instance exercises timing/modes; a fast instance drives channel 2
// into counter saturation in parallel.
module tb_intr_gen_n;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk;
    logic        rst;
    logic [3:0]  intrIntvl;
    logic        intrEn;
    logic [2:0]  chEn;
    logic [2:0]  intrAck;
    logic [2:0]  irqOut;
    logic [47:0] irqCnt;

    logic        clkB;
    logic        rstB;
    logic [3:0]  intvlB;
    logic        enB;
    logic [2:0]  chEnB;
    logic [2:0]  ackB;
    logic [2:0]  irqB;
    logic [47:0] cntB;

    logic [31:0] mLfsr;
    int          checks;
    int          failures;
    bit          satDone;

    intr_gen_n #(
        .NCH        (3),
        .MINWAIT    (10),
        .SEED       (SEED),
        .PULSE_MASK (3'b010)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .intr_intvl (intrIntvl),
        .intr_en    (intrEn),
        .ch_en      (chEn),
        .intr_ack   (intrAck),
        .irq_o      (irqOut),
        .irq_cnt_o  (irqCnt)
    );

    intr_gen_n #(
        .NCH        (3),
        .MINWAIT    (1),
        .SEED       (SEED),
        .PULSE_MASK (3'b000)
    ) dutSat (
        .clk        (clkB),
        .rst        (rstB),
        .intr_intvl (intvlB),
        .intr_en    (enB),
        .ch_en      (chEnB),
        .intr_ack   (ackB),
        .irq_o      (irqB),
        .irq_cnt_o  (cntB)
    );

    // Main clock and a faster clock for the long saturation run.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clkB = 1'b0;
        forever #1 clkB = ~clkB;
    end

    function automatic logic [31:0] lfsrStep(input logic [31:0] v);
        if (v[0]) return (v >> 1) ^ 32'h8020_0003;
        return v >> 1;
    endfunction

    // Reference LFSR tracking the main instance, so wait lengths are predictable.
    always @(posedge clk) begin
        mLfsr <= rst ? SEED : lfsrStep(mLfsr);
    end

    function automatic int nwaitModel(input int ch, input logic [31:0] lf, input int iv, input int quantum);
        int r;
        r = int'(lf[15:0]) ^ ((ch * 'h9E37) & 'hFFFF);
        return ((r % (1 << iv)) + 1) * quantum;
    endfunction

    function automatic logic [15:0] cntOf(input int ch);
        return irqCnt[ch*16 +: 16];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] iv, input logic e,
                                 input logic [2:0] ce, input logic [2:0] ak);
        rst       = r;
        intrIntvl = iv;
        intrEn    = e;
        chEn      = ce;
        intrAck   = ak;
    endtask

    // Called on the negedge just before the IDLE->WAIT edge; returns edges until rise.
    task automatic measureRise(input int ch, input int expWait, input string tag,
                               input bit poke, output int measured);
        logic [3:0] savedIntvl;
        savedIntvl = intrIntvl;
        measured   = -1;
        for (int k = 1; k <= expWait + 40; k++) begin
            @(negedge clk);
            if (poke && k == 1) intrIntvl = 4'hF;
            if (irqOut[ch]) begin
                measured = k - 1;
                break;
            end
        end
        intrIntvl = savedIntvl;
        checkOutput({tag, "Wait"}, 64'(measured), 64'(expWait));
    endtask

    // Saturation run: channel 2 always acked, shortest waits, until FFFF.
    initial begin
        logic [15:0] cur;
        logic [15:0] prev;
        bit          wrapSeen;
        satDone  = 1'b0;
        wrapSeen = 1'b0;
        prev     = 16'h0;
        cur      = 16'h0;
        rstB     = 1'b1;
        intvlB   = 4'd1;
        enB      = 1'b1;
        chEnB    = 3'b100;
        ackB     = 3'b100;
        repeat (2) @(negedge clkB);
        rstB = 1'b0;
        for (int k = 0; k < 200000; k++) begin
            @(negedge clkB);
            cur = cntB[47:32];
            if (cur < prev) wrapSeen = 1'b1;
            prev = cur;
            if (cur == 16'hFFFF) break;
        end
        checkOutput("satReach", 64'(cur), 64'hFFFF);
        repeat (300) begin
            @(negedge clkB);
            if (cntB[47:32] != 16'hFFFF) wrapSeen = 1'b1;
        end
        checkOutput("satNoWrap", 64'(wrapSeen), 64'h0);
        checkOutput("satOtherCh", 64'(cntB[31:0]), 64'h0);
        satDone = 1'b1;
    end

    // Directed sequence on the main instance.
    initial begin
        int   expW;
        int   meas;
        int   expCnt;
        bit   leave;
        logic [2:0] anyIrq;
        checks   = 0;
        failures = 0;

        applyStimulus(1'b1, 4'd0, 1'b0, 3'b000, 3'b000);
        repeat (2) @(negedge clk);
        checkOutput("rstIrq", 64'(irqOut), 64'h0);
        checkOutput("rstCnt", 64'(irqCnt), 64'h0);

        applyStimulus(1'b0, 4'd0, 1'b1, 3'b111, 3'b000);
        anyIrq = 3'b000;
        repeat (1000) begin
            @(negedge clk);
            anyIrq |= irqOut;
        end
        checkOutput("intvl0Irq", 64'(anyIrq), 64'h0);
        checkOutput("intvl0Cnt", 64'(irqCnt), 64'h0);

        applyStimulus(1'b1, 4'd0, 1'b0, 3'b000, 3'b000);
        @(negedge clk);
        applyStimulus(1'b0, 4'd1, 1'b1, 3'b001, 3'b000);
        expW = nwaitModel(0, mLfsr, 1, 10);
        measureRise(0, expW, "levelFirst", 1'b1, meas);
        checkOutput("levelFirstConst", 64'(meas), 64'd10);
        expCnt = 1;
        for (int ev = 0; ev < 6; ev++) begin
            repeat (2) @(negedge clk);
            checkOutput("levelHold", 64'(irqOut[0]), 64'h1);
            leave   = mLfsr[31];
            intrAck = 3'b001;
            @(negedge clk);
            intrAck = 3'b000;
            expCnt++;
            if (leave) begin
                checkOutput("ackDrop", 64'(irqOut[0]), 64'h0);
                expW = nwaitModel(0, mLfsr, 1, 10);
                measureRise(0, expW, "levelRise", 1'b0, meas);
                checkOutput("quantum", 64'((meas == 10) || (meas == 20)), 64'h1);
            end else begin
                checkOutput("b2bHold", 64'(irqOut[0]), 64'h1);
            end
            checkOutput("levelCnt", 64'(cntOf(0)), 64'(expCnt));
        end

        applyStimulus(1'b1, 4'd0, 1'b0, 3'b000, 3'b000);
        @(negedge clk);
        applyStimulus(1'b0, 4'd2, 1'b1, 3'b010, 3'b000);
        expW = nwaitModel(1, mLfsr, 2, 10);
        measureRise(1, expW, "pulseFirst", 1'b0, meas);
        checkOutput("pulseFirstConst", 64'(meas), 64'd40);
        for (int ev = 1; ev <= 3; ev++) begin
            @(negedge clk);
            checkOutput("pulseWidth", 64'(irqOut[1]), 64'h0);
            checkOutput("pulseCnt", 64'(cntOf(1)), 64'(ev));
            if (ev < 3) begin
                expW = nwaitModel(1, mLfsr, 2, 10);
                measureRise(1, expW, "pulseRise", 1'b0, meas);
            end
        end

        applyStimulus(1'b1, 4'd0, 1'b0, 3'b000, 3'b000);
        @(negedge clk);
        applyStimulus(1'b0, 4'd1, 1'b1, 3'b001, 3'b000);
        expW = nwaitModel(0, mLfsr, 1, 10);
        measureRise(0, expW, "gateRise", 1'b0, meas);
        intrEn = 1'b0;
        #1;
        checkOutput("gateDrop", 64'(irqOut[0]), 64'h0);
        intrAck = 3'b001;
        @(negedge clk);
        intrAck = 3'b000;
        @(negedge clk);
        checkOutput("gateCnt", 64'(cntOf(0)), 64'h1);
        intrEn = 1'b1;
        expW = nwaitModel(0, mLfsr, 1, 10);
        @(negedge clk);
        checkOutput("noReassert", 64'(irqOut[0]), 64'h0);

        repeat (expW - 7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstIrq", 64'(irqOut), 64'h0);
        checkOutput("midRstCnt", 64'(irqCnt), 64'h0);
        rst  = 1'b0;
        expW = nwaitModel(0, mLfsr, 1, 10);
        measureRise(0, expW, "restart", 1'b0, meas);
        checkOutput("restartConst", 64'(meas), 64'd10);

        chEn    = 3'b000;
        intrAck = 3'b001;
        @(negedge clk);
        checkOutput("disAckCnt", 64'(cntOf(0)), 64'h1);
        intrAck = 3'b000;
        chEn    = 3'b001;
        repeat (4) @(negedge clk);
        chEn = 3'b000;
        @(negedge clk);
        checkOutput("abortIrq", 64'(irqOut), 64'h0);
        chEn = 3'b001;
        expW = nwaitModel(0, mLfsr, 1, 10);
        measureRise(0, expW, "abortRise", 1'b0, meas);
        checkOutput("abortCnt", 64'(cntOf(0)), 64'h2);

        for (int t = 0; t < 250000 && !satDone; t++) @(negedge clkB);
        if (!satDone) checkOutput("satTimeout", 64'h0, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intr_gen_n.md
INTR_GEN_N -- requirements
Module: intr_gen_n

Interface
REQ-001 SHALL have parameter NCH, default 3: number of independent interrupt channels, 1..16.
REQ-002 SHALL have parameter MINWAIT, default 10: wait-time quantum in cycles, 1..255.
REQ-003 SHALL have parameter SEED, default 32'hACE1_2468: LFSR reset value; value 0 is replaced by 32'h1.
REQ-004 SHALL have parameter PULSE_MASK, default '0, NCH bits: bit i=1 makes channel i pulse-mode, 0 makes it level-mode.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port intr_intvl, input, 4 bits: interval exponent; 0 means no new interrupts.
REQ-008 SHALL have port intr_en, input, 1 bit: global enable.
REQ-009 SHALL have port ch_en, input, NCH bits: per-channel enable.
REQ-010 SHALL have port intr_ack, input, NCH bits: per-channel acknowledge, level-sampled.
REQ-011 SHALL have port irq_o, output, NCH bits: interrupt requests.
REQ-012 SHALL have port irq_cnt_o, output, NCH*16 bits: per-channel assertion counters, channel i at [16i+15:16i].

Function
REQ-013 SHALL use a 32-bit Galois LFSR (taps 32,22,2,1) that advances every cycle when not in reset.
REQ-014 SHALL form channel i random word r_i = lfsr[15:0] XOR (i*16'h9E37), truncated to 16 bits.
REQ-015 SHALL run one FSM per channel with states IDLE, WAIT, ASSERT.
REQ-016 IDLE -> WAIT SHALL occur when intr_en and ch_en[i] are 1 and intr_intvl != 0.
REQ-017 SHALL load the wait counter on IDLE -> WAIT with nwait = ((r_i AND (2^intr_intvl - 1)) + 1) * MINWAIT.
REQ-018 SHALL size the wait counter at 25 bits with no overflow; 16-bit mask for intr_intvl >= 16 is not applicable, max intr_intvl is 15.
REQ-019 WAIT SHALL decrement the counter each cycle.
REQ-020 Internal irq[i] SHALL rise exactly nwait rising edges after the IDLE -> WAIT edge, entering ASSERT.
REQ-021 In WAIT, if intr_en=0 or ch_en[i]=0, the FSM SHALL abort to IDLE next edge with no assertion.
REQ-022 Changes to intr_intvl during WAIT SHALL be ignored.
REQ-023 Level mode, ASSERT: irq[i] SHALL hold until intr_ack[i]=1 is sampled.
REQ-024 Level mode, on ack: if lfsr[31-(i%32)]=1, intr_en=0 or ch_en[i]=0 -> irq[i]=0 and go IDLE.
REQ-025 Level mode, otherwise on ack: SHALL stay in ASSERT with irq[i]=1 (back-to-back) and count a new assertion.
REQ-026 Pulse mode: irq[i] SHALL be high for exactly one cycle, then go IDLE; intr_ack[i] is ignored.
REQ-027 SHALL drive irq_o[i] = irq[i] AND intr_en AND ch_en[i] combinationally (hard gate, same-cycle drop).
REQ-028 irq_cnt[i] SHALL increment by 1 on each WAIT -> ASSERT and each back-to-back re-assert, saturating at 16'hFFFF.
REQ-029 Channels SHALL be fully independent; simultaneous assertions and acks on multiple channels are legal and handled per channel.
REQ-030 intr_ack[i] in IDLE or WAIT SHALL be ignored.

Reset
REQ-031 With rst=1 at a clock edge: all FSMs SHALL go IDLE, irq=0, wait counters=0, irq_cnt=0, lfsr=SEED (or 1).
REQ-032 irq_o SHALL be 0 on the first cycle after the reset edge.
REQ-033 Reset asserted mid-WAIT or mid-ASSERT SHALL override all other transitions.
REQ-034 No assertion SHALL occur earlier than MINWAIT cycles after reset release.

Verification
REQ-035 intr_intvl=0, intr_en=1, ch_en=3'b111, 1000 cycles -> irq_o stays 3'b000, irq_cnt_o all 0.
REQ-036 intr_intvl=1, MINWAIT=10, ack 3 cycles after each rise -> every rise lands 10 or 20 cycles after IDLE exit; irq_cnt equals number of rises plus back-to-back reasserts.
REQ-037 PULSE_MASK=3'b010, intr_intvl=2 -> irq_o[1] high exactly 1 cycle per event, no ack needed; channels 0/2 hold until ack.
REQ-038 irq_o[0]=1, drop intr_en -> irq_o[0]=0 same cycle; ack then returns channel to IDLE with no re-assert.
REQ-039 rst=1 for 1 cycle during WAIT with counter=7 -> next cycle IDLE, irq_o=0, irq_cnt_o=0, LFSR sequence restarts from SEED (identical to the post-power-on sequence).
REQ-040 Force 70000 back-to-back acks on channel 2 -> irq_cnt[2] saturates at 16'hFFFF without wrap.
